// File: rtl/dp_ram_arb_if.sv
// Requester, clear-control and RAM-side signals of the dual-port RAM arbiter.
// slave modport is the arbiter's view; master is the requesters/RAM side.
interface dp_ram_arb_if #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 32
);
  logic                 clr_start;
  logic                 busy;

  logic                 a_req;
  logic                 a_we;
  logic [ADDR_SIZE-1:0] a_addr;
  logic [DATA_SIZE-1:0] a_wdata;
  logic                 a_gnt;
  logic                 a_rvalid;
  logic [DATA_SIZE-1:0] a_rdata;

  logic                 b_req;
  logic                 b_we;
  logic [ADDR_SIZE-1:0] b_addr;
  logic [DATA_SIZE-1:0] b_wdata;
  logic                 b_gnt;
  logic                 b_rvalid;
  logic [DATA_SIZE-1:0] b_rdata;

  logic                 ram_wr;
  logic [ADDR_SIZE-1:0] ram_wr_addr;
  logic [DATA_SIZE-1:0] ram_data_in;
  logic                 ram_rd;
  logic [ADDR_SIZE-1:0] ram_rd_addr;
  logic [DATA_SIZE-1:0] ram_data_out;

  modport slave (
    input  clr_start,
    output busy,
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output ram_wr, ram_wr_addr, ram_data_in, ram_rd, ram_rd_addr,
    input  ram_data_out
  );

  modport master (
    output clr_start,
    input  busy,
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_wr, ram_wr_addr, ram_data_in, ram_rd, ram_rd_addr,
    output ram_data_out
  );
endinterface

// File: rtl/dp_ram_arb.sv
// Two-requester round-robin arbiter in front of a dual-port RAM.
// Write and read ports are arbitrated independently; reads are tagged with
// their owner so returned data is steered back. A clear sweep zero-fills RAM.
module dp_ram_arb #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 2**ADDR_SIZE
) (
  input  logic        clk,
  input  logic        rst,
  dp_ram_arb_if.slave bus
);
  localparam int NREQ      = 2;
  localparam int RD_STAGES = 2;  // grant -> RAM cmd -> RAM data
  localparam logic [ADDR_SIZE-1:0] CLR_LAST = ADDR_SIZE'(DEPTH-1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state, state_nxt;
  logic [ADDR_SIZE-1:0] clr_cnt, clr_cnt_nxt;

  // Requester index 0 = A, 1 = B.
  logic [NREQ-1:0]                req, we, wr_cand, rd_cand, wr_gnt, rd_gnt, rvalid;
  logic [NREQ-1:0][ADDR_SIZE-1:0] addr;
  logic [NREQ-1:0][DATA_SIZE-1:0] wdata, rdata;

  logic arb_en, wr_any, rd_any, wr_sel, rd_sel;
  logic wr_ptr, rd_ptr;  // 0 favours A on contention

  logic                 ram_wr, ram_rd;
  logic [ADDR_SIZE-1:0] ram_wr_addr, ram_rd_addr;
  logic [DATA_SIZE-1:0] ram_data_in;

  logic [RD_STAGES:1] rd_vld_pipe;
  logic [RD_STAGES:1] rd_own_pipe;

  assign req   = {bus.b_req,   bus.a_req};
  assign we    = {bus.b_we,    bus.a_we};
  assign addr  = {bus.b_addr,  bus.a_addr};
  assign wdata = {bus.b_wdata, bus.a_wdata};

  // Single candidate wins outright; on contention the pointer decides.
  function automatic logic [1:0] rr_pick(input logic [1:0] cand, input logic ptr);
    if (cand == 2'b11) return ptr ? 2'b10 : 2'b01;
    return cand;
  endfunction

  // Grants are only issued in IDLE and never on the clr_start cycle; rst
  // gating keeps every output low while reset is held.
  assign arb_en  = (state == IDLE) && !bus.clr_start && !rst;
  assign wr_cand = req & we;
  assign rd_cand = req & ~we;
  assign wr_gnt  = arb_en ? rr_pick(wr_cand, wr_ptr) : '0;
  assign rd_gnt  = arb_en ? rr_pick(rd_cand, rd_ptr) : '0;
  assign wr_any  = |wr_gnt;
  assign rd_any  = |rd_gnt;
  assign wr_sel  = wr_gnt[1];
  assign rd_sel  = rd_gnt[1];

  assign bus.a_gnt = wr_gnt[0] | rd_gnt[0];
  assign bus.b_gnt = wr_gnt[1] | rd_gnt[1];
  assign bus.busy  = (state == CLEAR);

  // Clear sweep state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Clear sweep next state: one word per cycle, stop at the last word.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      IDLE: begin
        if (bus.clr_start) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      CLEAR: begin
        if (clr_cnt == CLR_LAST) state_nxt   = IDLE;
        else                     clr_cnt_nxt = clr_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Round-robin pointers move only when both sides contended.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (arb_en && wr_cand == 2'b11) wr_ptr <= ~wr_ptr;
      if (arb_en && rd_cand == 2'b11) rd_ptr <= ~rd_ptr;
    end
  end

  // Registered RAM command: sweep writes in CLEAR, winners' commands in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_wr      <= 1'b0;
      ram_wr_addr <= '0;
      ram_data_in <= '0;
      ram_rd      <= 1'b0;
      ram_rd_addr <= '0;
    end else if (state == CLEAR) begin
      ram_wr      <= 1'b1;
      ram_wr_addr <= clr_cnt;
      ram_data_in <= '0;
      ram_rd      <= 1'b0;
    end else begin
      ram_wr <= wr_any;
      ram_rd <= rd_any;
      if (wr_any) begin
        ram_wr_addr <= addr[wr_sel];
        ram_data_in <= wdata[wr_sel];
      end
      if (rd_any) ram_rd_addr <= addr[rd_sel];
    end
  end

  assign bus.ram_wr      = ram_wr;
  assign bus.ram_wr_addr = ram_wr_addr;
  assign bus.ram_data_in = ram_data_in;
  assign bus.ram_rd      = ram_rd;
  assign bus.ram_rd_addr = ram_rd_addr;

  // Read tag pipe: valid + owner follow each read until its RAM data returns.
  // It keeps running through CLEAR so in-flight reads still complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_pipe <= '0;
      rd_own_pipe <= '0;
    end else begin
      rd_vld_pipe <= {rd_vld_pipe[RD_STAGES-1:1], rd_any};
      rd_own_pipe <= {rd_own_pipe[RD_STAGES-1:1], rd_sel};
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_ret
    assign rvalid[i] = rd_vld_pipe[RD_STAGES] && (rd_own_pipe[RD_STAGES] == 1'(i));
    assign rdata[i]  = rvalid[i] ? bus.ram_data_out : '0;
  end

  assign bus.a_rvalid = rvalid[0];
  assign bus.b_rvalid = rvalid[1];
  assign bus.a_rdata  = rdata[0];
  assign bus.b_rdata  = rdata[1];
endmodule
